// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU execute-stage sequencer with background DIVU timing.
// Optional HI/LO read interlock against an in-flight divide: HILO_INTERLOCK_EN.
module alu_seq_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [5:0] funct,
  output logic       ready,
  output logic [5:0] sel_out,
  output logic       done,
  output logic       err,
  output logic       div_start,
  output logic       div_busy,
  output logic       hilo_we
);

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] SEL_ZERO = 6'b111111;

  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

`ifdef HILO_INTERLOCK_EN
  localparam bit INTERLOCK = 1'b1;
`else
  localparam bit INTERLOCK = 1'b0;
`endif

  typedef enum logic {
    S_IDLE,
    S_RUN
  } div_state_t;

  div_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;

  logic is_divu;
  logic is_mf;
  logic supported;
  logic accept;
  logic accept_single;

  always_comb begin
    supported = 1'b0;
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL,
      F_DIVU, F_MFHI, F_MFLO: supported = 1'b1;
      default:                supported = 1'b0;
    endcase
  end

  assign is_divu = (funct == F_DIVU);
  assign is_mf   = (funct == F_MFHI) || (funct == F_MFLO);

  assign div_busy = (state == S_RUN);

  // Only a second DIVU (and HI/LO reads when interlocked) must wait for the divider.
  assign ready = !div_busy || !(is_divu || (INTERLOCK && is_mf));

  assign accept        = req && ready;
  assign accept_single = accept && !is_divu;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    div_start = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && is_divu) begin
          state_nx = S_RUN;
          cnt_nx   = CNT_LOAD;
        end
      end
      S_RUN: begin
        // Counter only sits at its load value in the first RUN cycle.
        div_start = (cnt == CNT_LOAD);
        if (cnt == 8'd0) begin
          hilo_we  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      sel_out <= SEL_ZERO;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= accept_single;
      err   <= accept_single && !supported;
      if (accept_single) begin
        sel_out <= supported ? funct : SEL_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed vector bench for alu_seq_ctrl (DIV_CYCLES=32).
module tb_alu_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic [5:0] funct;
  logic       ready;
  logic [5:0] sel_out;
  logic       done;
  logic       err;
  logic       div_start;
  logic       div_busy;
  logic       hilo_we;

  int n_vec;
  int n_bad;

  alu_seq_ctrl #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .funct     (funct),
    .ready     (ready),
    .sel_out   (sel_out),
    .done      (done),
    .err       (err),
    .div_start (div_start),
    .div_busy  (div_busy),
    .hilo_we   (hilo_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [5:0] funct;
    logic       exp_ready;
    logic [5:0] exp_sel;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (div_busy && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", int'(div_busy), 0);
  endtask

  // Hold funct requested from cycle 2 of a divide (cycle k spans edge T+k-1..T+k);
  // reports stall count, the cycle it was accepted in and the hilo_we cycle.
  task automatic hold_req(input logic [5:0] f, output int stalls, output int acc_k, output int hk);
    int k;
    stalls = 0;
    acc_k  = -1;
    hk     = -1;
    req    = 1'b1;
    funct  = f;
    for (k = 2; k <= 60; k++) begin
      @(negedge clk);
      if (hilo_we) hk = k;
      if (ready) begin
        acc_k = k;
        break;
      end
      stalls++;
      tick();
    end
    tick();
  endtask

  initial begin
    int stalls, acc_k, hk, hcount;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    req   = 1'b0;
    funct = 6'd0;

    vecs[0]  = '{1'b0, 6'b000000, 1'b1, 6'b111111, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 6'b100000, 1'b1, 6'b100000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 6'b100100, 1'b1, 6'b100100, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 6'b101010, 1'b1, 6'b101010, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 6'b111000, 1'b1, 6'b111111, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 6'b100101, 1'b1, 6'b111111, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 6'b100101, 1'b1, 6'b100101, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 6'b100010, 1'b1, 6'b100010, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 6'b000000, 1'b1, 6'b000000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 6'b010010, 1'b1, 6'b010010, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 6'b010000, 1'b1, 6'b010000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 6'b011011, 1'b1, 6'b010000, 1'b0, 1'b0};

    repeat (3) tick();
    chk("rst_sel", int'(sel_out), 6'b111111);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_div_start", int'(div_start), 0);
    chk("rst_div_busy", int'(div_busy), 0);
    chk("rst_hilo_we", int'(hilo_we), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req   = vecs[i].req;
      funct = vecs[i].funct;
      #1;
      chk($sformatf("v%0d_ready", i), int'(ready), int'(vecs[i].exp_ready));
      tick();
      chk($sformatf("v%0d_sel", i), int'(sel_out), int'(vecs[i].exp_sel));
      chk($sformatf("v%0d_done", i), int'(done), int'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].exp_err));
      chk($sformatf("v%0d_busy", i), int'(div_busy), 0);
      chk($sformatf("v%0d_hilo", i), int'(hilo_we), 0);
    end

    // DIVU at T, SUB at T+1, second DIVU held from cycle 2.
    @(negedge clk);
    req   = 1'b1;
    funct = 6'b011011;
    #1;
    chk("divu_ready", int'(ready), 1);
    tick();
    chk("divu_start", int'(div_start), 1);
    chk("divu_busy", int'(div_busy), 1);
    chk("divu_no_done", int'(done), 0);
    chk("divu_sel_hold", int'(sel_out), 6'b010000);
    @(negedge clk);
    funct = 6'b100010;
    #1;
    chk("sub_ready", int'(ready), 1);
    tick();
    chk("sub_done", int'(done), 1);
    chk("sub_sel", int'(sel_out), 6'b100010);
    chk("sub_start_low", int'(div_start), 0);
    hold_req(6'b011011, stalls, acc_k, hk);
    chk("divu2_stalls", stalls, 31);
    chk("divu2_accept_cycle", acc_k, 33);
    chk("hilo_we_cycle", hk, 32);
    chk("divu2_start", int'(div_start), 1);
    req = 1'b0;
    wait_idle();

    // HI read requested one cycle after a DIVU accept.
    @(negedge clk);
    req   = 1'b1;
    funct = 6'b011011;
    tick();
    req = 1'b0;
    tick();
    hold_req(6'b010000, stalls, acc_k, hk);
    chk("mfhi_done", int'(done), 1);
    chk("mfhi_sel", int'(sel_out), 6'b010000);
`ifdef HILO_INTERLOCK_EN
    chk("mfhi_stalls", stalls, 31);
    chk("mfhi_accept_cycle", acc_k, 33);
    chk("mfhi_hilo_before", hk, 32);
`else
    chk("mfhi_stalls", stalls, 0);
    chk("mfhi_accept_cycle", acc_k, 2);
    chk("mfhi_busy_still", int'(div_busy), 1);
`endif
    req = 1'b0;
    wait_idle();

    // Reset 10 cycles into a divide.
    @(negedge clk);
    req   = 1'b1;
    funct = 6'b011011;
    tick();
    req = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", int'(div_busy), 1);
    reset = 1'b1;
    req   = 1'b1;
    funct = 6'b100000;
    tick();
    reset = 1'b0;
    req   = 1'b0;
    chk("mid_rst_busy", int'(div_busy), 0);
    chk("mid_rst_sel", int'(sel_out), 6'b111111);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_hilo", int'(hilo_we), 0);
    hcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we || div_busy) hcount++;
    end
    chk("post_rst_quiet", hcount, 0);
    @(negedge clk);
    req   = 1'b1;
    funct = 6'b011011;
    #1;
    chk("post_rst_divu_ready", int'(ready), 1);
    tick();
    req = 1'b0;
    chk("post_rst_div_start", int'(div_start), 1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the ALU execute stage. Accepts one operation request per cycle by MIPS funct code and drives the 6-bit select into the result multiplexer. Runs the multi-cycle unsigned divider (DIVU) in the background and times the HI/LO write. Optionally interlocks MFHI/MFLO and back-to-back DIVU against an in-flight divide.

## Interface

Parameters
- DIV_CYCLES, 32: divider latency in cycles, from div_start to the HI/LO write inclusive; legal range 2..255.

Ports
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  operation request valid
- funct  in  6  funct code of the request; sampled with req
- ready  out  1  controller can accept funct this cycle (combinational)
- sel_out  out  6  select to the result mux (Signal)
- done  out  1  one-cycle pulse: result for the last accepted single-cycle op is on the mux output
- err  out  1  valid with done; accepted funct was not a supported code
- div_start  out  1  one-cycle pulse launching the divider
- div_busy  out  1  divide in flight
- hilo_we  out  1  one-cycle pulse: divider result written to HI/LO at the end of this cycle

## Operation

- Supported codes: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, DIVU 011011, MFHI 010000, MFLO 010010.
- Acceptance: an edge where req=1 and ready=1.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO):
  - sel_out loads funct on acceptance.
  - done=1 for the next cycle.
  - sel_out holds its value until the next acceptance.
- Unsupported code: accepted like a single-cycle op.
  - sel_out loads 6'b111111 (mux outputs zero).
  - done=1 and err=1 for one cycle.
- DIVU:
  - On acceptance, sel_out is unchanged and no done pulse is issued.
  - Divide state machine moves IDLE -> RUN.
  - 8-bit down-counter loads DIV_CYCLES-1.
- Divide state machine (independent of single-cycle issue):
  - IDLE: div_busy=0.
  - RUN: div_busy=1. div_start=1 in the first RUN cycle only. Counter decrements each cycle.
  - At counter=0: hilo_we=1 for that cycle, then RUN -> IDLE.
- Overlap: single-cycle ops are accepted every cycle while div_busy=1; done and hilo_we may be high in the same cycle.
- ready:
  - 1 when div_busy=0.
  - When div_busy=1, ready is 0 for funct=DIVU always, and for funct=MFHI/MFLO under the interlock (see Configuration).
  - ready is 1 for all other funct.
- req=0: no state change except the divide counter.

## Timing

- Reset values: sel_out=6'b111111; done, err, div_start, div_busy and hilo_we all 0; counter=0; divide FSM in IDLE.
- Single-cycle latency: accept at edge T, so done=1 during cycle T..T+1 with sel_out valid.
- DIVU accepted at edge T:
  - div_start and div_busy rise after T.
  - hilo_we is high in the DIV_CYCLES-th cycle after T.
  - div_busy falls on the edge ending that cycle.
- An MFHI stalled by the interlock is accepted on the first edge with div_busy=0, so it reads the freshly written HI.
- Reset asserted mid-divide: the divide is abandoned, counter cleared, no hilo_we is issued, and all outputs return to reset values on that edge.
- reset has priority over req.

## Configuration

- HILO_INTERLOCK_EN defined: ready=0 for MFHI/MFLO while div_busy=1. Guarantees HI/LO reads observe the completed divide.
- HILO_INTERLOCK_EN undefined: MFHI/MFLO are accepted during a divide and return the stale HI/LO contents. DIVU-after-DIVU is still stalled.

## Test plan

- Reset, then idle: sel_out=111111, all pulses 0, ready=1.
- req ADD (100000), then AND, then SLT on consecutive cycles -> three done pulses on consecutive cycles; sel_out steps 100000, 100100, 101010; err=0.
- req funct=111000 -> done=1, err=1, sel_out=111111 for one cycle.
- DIVU with DIV_CYCLES=32 at edge T, then SUB at T+1 and a second DIVU at T+2:
  - div_start one cycle after T.
  - SUB done at T+2.
  - Second DIVU has ready=0 until div_busy falls.
  - hilo_we high exactly cycle T+31..T+32.
- HILO_INTERLOCK_EN defined: MFHI requested one cycle after a DIVU accept -> ready=0 for 31 cycles; accepted on the first edge after hilo_we; done then sel_out=010000.
- HILO_INTERLOCK_EN undefined, same stimulus -> MFHI accepted immediately; done on the next cycle.
- reset pulsed 10 cycles into a divide -> div_busy=0 next cycle; no hilo_we ever seen; a new DIVU is accepted immediately.
